// File: rtl/fifo_wr_stream_adapter.sv
// rtl/fifo_wr_stream_adapter.sv - write-domain stream front end for the async FIFO
//
// Accepts a valid/ready word stream into a 2-entry skid buffer and drains it
// into the FIFO write port only while w_full is low. Keeps saturating write
// and full-stall counters plus a sticky write-error flag.
//
// Ports:
//   clk, wrst_n          write-domain clock, async active-low reset
//   s_valid/s_ready/s_data   producer stream (s_ready registered)
//   w_enable/w_data      FIFO write strobe and data (w_enable combinational on w_full)
//   w_full, write_error  FIFO status inputs
//   clr_stats            synchronous clear of the statistics
//   wr_count, stall_count, err_sticky   statistics outputs
module fifo_wr_stream_adapter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              wrst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              w_enable,
    output logic [DATA_W-1:0] w_data,
    input  logic              w_full,
    input  logic              write_error,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic              err_sticky
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [DATA_W-1:0] mem_q [0:1];
    logic [DATA_W-1:0] mem_d [0:1];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              s_ready_q, s_ready_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              err_sticky_q, err_sticky_d;

    logic              acc;
    logic              drain;
    logic              stall;

    always_comb begin
        acc   = s_valid & s_ready_q;
        drain = (occ_q != OCC_EMPTY) & ~w_full;
        stall = (occ_q != OCC_EMPTY) & w_full;

        mem_d = mem_q;
        if (acc) begin
            mem_d[tail_q] = s_data;
        end

        head_d = head_q ^ drain;
        tail_d = tail_q ^ acc;

        occ_d = occ_q;
        case ({acc, drain})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Ready is decided one cycle ahead from the next occupancy, so a
        // registered ready can never let a third word in.
        s_ready_d = (occ_d != OCC_TWO);

        wr_count_d = wr_count_q;
        if (clr_stats) begin
            wr_count_d = '0;
        end else if (drain && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end

        stall_count_d = stall_count_q;
        if (clr_stats) begin
            stall_count_d = '0;
        end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end

        // A new error in the clearing cycle must not be lost.
        err_sticky_d = write_error | (err_sticky_q & ~clr_stats);
    end

    // Buffer contents are never reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge wrst_n) begin
        if (!wrst_n) begin
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            occ_q         <= OCC_EMPTY;
            s_ready_q     <= 1'b0;
            wr_count_q    <= '0;
            stall_count_q <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            occ_q         <= occ_d;
            s_ready_q     <= s_ready_d;
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign w_enable    = drain;
    assign w_data      = mem_q[head_q];
    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_fifo_wr_stream_adapter.sv
// tb/tb_fifo_wr_stream_adapter.sv - scoreboard bench for fifo_wr_stream_adapter
module tb_fifo_wr_stream_adapter;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          wrst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          w_enable;
    logic [DW-1:0] w_data;
    logic          w_full;
    logic          write_error;
    logic          clr_stats;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] stall_count;
    logic          err_sticky;

    fifo_wr_stream_adapter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .wrst_n      (wrst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .w_enable    (w_enable),
        .w_data      (w_data),
        .w_full      (w_full),
        .write_error (write_error),
        .clr_stats   (clr_stats),
        .wr_count    (wr_count),
        .stall_count (stall_count),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: words accepted but not yet written, plus reference statistics.
    logic [DW-1:0] sbq[$];
    int  m_wr, m_stall;
    bit  m_err;
    bit  exp_ready;
    int  mon_writes;

    always @(negedge clk) begin
        bit en_exp;
        bit stall_exp;
        if (!wrst_n) begin
            sbq.delete();
            m_wr = 0;
            m_stall = 0;
            m_err = 0;
            exp_ready = 0;
        end else begin
            en_exp    = (sbq.size() != 0) && !w_full;
            stall_exp = (sbq.size() != 0) && w_full;
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
            chk("w_enable", 32'(w_enable), 32'(en_exp));
            chk("wr_count_mdl", 32'(wr_count), 32'(m_wr));
            chk("stall_count_mdl", 32'(stall_count), 32'(m_stall));
            chk("err_sticky_mdl", 32'(err_sticky), 32'(m_err));
            if (w_enable && sbq.size() != 0)
                chk("w_data_order", 32'(w_data), 32'(sbq[0]));
            if (en_exp) begin
                void'(sbq.pop_front());
                mon_writes++;
            end
            if (s_valid && exp_ready)
                sbq.push_back(s_data);
            exp_ready = (sbq.size() != 2);
            if (clr_stats) begin
                m_wr = 0;
                m_stall = 0;
            end else begin
                if (en_exp && m_wr < CMAX) m_wr++;
                if (stall_exp && m_stall < CMAX) m_stall++;
            end
            if (write_error) m_err = 1;
            else if (clr_stats) m_err = 0;
        end
    end

    // Stimulus state
    logic [DW-1:0] nxt;
    logic [DW-1:0] step;
    int  acc_cnt;
    bit  phase;

    // Streams words until target accepts or max_cyc cycles; fmode 0 empty, 1 full, 2 alternating.
    task automatic drive(input int target, input int max_cyc, input int fmode, output int cyc);
        bit acc;
        cyc = 0;
        while (acc_cnt < target && cyc < max_cyc) begin
            s_valid = 1'b1;
            s_data  = nxt;
            w_full  = (fmode == 1) ? 1'b1 : (fmode == 2) ? phase : 1'b0;
            phase   = ~phase;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                nxt = nxt + step;
                acc_cnt++;
            end
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        w_full  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit clr, input bit err);
        clr_stats   = clr;
        write_error = err;
        @(posedge clk);
        #1;
        clr_stats   = 1'b0;
        write_error = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; w_full = 1'b0;
        write_error = 1'b0; clr_stats = 1'b0; phase = 1'b0;
        mon_writes = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_w_enable", 32'(w_enable), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);

        // Release with valid already high: 0x11, 0x22, 0x33
        nxt = 8'h11; step = 8'h11; acc_cnt = 0;
        wrst_n = 1'b1;
        drive(3, 10, 0, cyc);
        chk("t1_accepts", 32'(acc_cnt), 3);
        chk("t1_ready_from_edge1", 32'(cyc), 4);
        idle(3);
        chk("t1_wr_count", 32'(wr_count), 3);

        // Full stall: one word goes in, then 10 full cycles
        pulse(1'b1, 1'b0);
        nxt = 8'hA0; step = 8'h01; acc_cnt = 0;
        drive(1, 1, 0, cyc);
        drive(99, 10, 1, cyc);
        chk("t2_accepts_while_full", 32'(acc_cnt), 2);
        chk("t2_s_ready_held", 32'(s_ready), 0);
        chk("t2_wr_count", 32'(wr_count), 0);
        chk("t2_stall_count", 32'(stall_count), 10);
        drive(5, 20, 0, cyc);
        idle(4);
        chk("t2_wr_count_after", 32'(wr_count), 5);
        chk("t2_sb_empty", 32'(sbq.size()), 0);

        // Alternating full over 200 words
        pulse(1'b1, 1'b0);
        nxt = 8'h00; step = 8'h01; acc_cnt = 0; mon_writes = 0;
        drive(200, 1000, 2, cyc);
        chk("t3_accepts", 32'(acc_cnt), 200);
        idle(4);
        chk("t3_writes_seen", 32'(mon_writes), 200);
        chk("t3_sb_empty", 32'(sbq.size()), 0);
        chk("t3_wr_count_sat", 32'(wr_count), CMAX);

        // Saturation then clear concurrent with a write
        pulse(1'b1, 1'b0);
        nxt = 8'h40; acc_cnt = 0;
        drive(21, 40, 0, cyc);
        chk("t4_wr_count_sat", 32'(wr_count), 15);
        chk("t4_pending_write", 32'(w_enable), 1);
        pulse(1'b1, 1'b0);
        chk("t4_clr_wins", 32'(wr_count), 0);
        idle(2);

        // Sticky error
        pulse(1'b0, 1'b1);
        chk("t5_err_set", 32'(err_sticky), 1);
        idle(2);
        chk("t5_err_holds", 32'(err_sticky), 1);
        pulse(1'b1, 1'b0);
        chk("t5_err_cleared", 32'(err_sticky), 0);
        pulse(1'b1, 1'b1);
        chk("t5_err_wins_clr", 32'(err_sticky), 1);

        // Reset mid-operation with two words buffered
        pulse(1'b1, 1'b0);
        nxt = 8'hC0; acc_cnt = 0;
        drive(2, 5, 0, cyc);
        drive(99, 3, 1, cyc);
        chk("t6_pre_wr_count", 32'(wr_count), 1);
        chk("t6_pre_stall", 32'(stall_count), 3);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_s_ready", 32'(s_ready), 0);
        chk("t6_rst_w_enable", 32'(w_enable), 0);
        chk("t6_rst_wr_count", 32'(wr_count), 0);
        chk("t6_rst_stall", 32'(stall_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        wrst_n = 1'b1;
        nxt = 8'h5A; acc_cnt = 0;
        drive(1, 5, 0, cyc);
        chk("t6_accept_5a", 32'(acc_cnt), 1);
        chk("t6_first_w_enable", 32'(w_enable), 1);
        chk("t6_first_w_data", 32'(w_data), 32'h5A);
        idle(3);
        chk("t6_wr_count", 32'(wr_count), 1);
        chk("t6_sb_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
